// File: rtl/p4_adder.sv
`default_nettype none
// ============================================================================
// Module      : p4_adder
// Description : Sparse-tree adder, S = A + B + CIN, in the Pentium-4 style.
//               A prefix tree produces only the carry into every 4-bit block
//               (C0 = CIN, C4, C8, ..., C_DWIDTH).  Each block precomputes
//               ripple sums for carry-in 0 and carry-in 1 and selects one of
//               them with its block carry.
//               Combinational outputs are available directly; a registered
//               copy gives clocked consumers a one-cycle-latency result.
// Ports       : clk       - clock, rising edge active
//               rst       - asynchronous active-high reset (registered outputs)
//               Aif, Bif  - unsigned operands, DWIDTH bits
//               CIN       - carry-in
//               Scomb     - combinational sum mod 2^DWIDTH
//               COUT      - combinational carry-out
//               Ssync     - Scomb registered on rising clk
//               COUTsync  - COUT registered on rising clk
// Revision    : 1.0 - initial release
// ============================================================================
module p4_adder #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] Aif,
    input  logic [DWIDTH-1:0] Bif,
    input  logic              CIN,
    output logic [DWIDTH-1:0] Scomb,
    output logic              COUT,
    output logic [DWIDTH-1:0] Ssync,
    output logic              COUTsync
);

    localparam int c_NBLK     = DWIDTH / 4;
    localparam int c_LOG_NBLK = $clog2(c_NBLK);

    logic [DWIDTH-1:0] w_g;
    logic [DWIDTH-1:0] w_p;
    logic              w_g0f;
    wire  [c_NBLK-1:0] w_blk_g;
    wire  [c_NBLK-1:0] w_blk_p;
    logic [c_NBLK-1:0] w_tree_g;
    logic [c_NBLK-1:0] w_tree_p;
    logic [c_NBLK:0]   w_c;
    wire  [DWIDTH-1:0] w_sum;

    logic [DWIDTH-1:0] r_sum;
    logic              r_cout;

    // Bit-level generate/propagate; CIN is absorbed into bit 0 so the tree
    // output for block k is directly the carry into block k+1.
    assign w_g   = Aif & Bif;
    assign w_p   = Aif ^ Bif;
    assign w_g0f = w_g[0] | (w_p[0] & CIN);

    // Tree levels 1 and 2: radix-2 combine inside each 4-bit block.
    for (genvar k = 0; k < c_NBLK; k++) begin : g_blk
        wire  w_gb0 = (k == 0) ? w_g0f : w_g[4*k];
        logic w_g10;
        logic w_p10;
        logic w_g32;
        logic w_p32;

        assign w_g10 = w_g[4*k+1] | (w_p[4*k+1] & w_gb0);
        assign w_p10 = w_p[4*k+1] & w_p[4*k];
        assign w_g32 = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2]);
        assign w_p32 = w_p[4*k+3] & w_p[4*k+2];

        assign w_blk_g[k] = w_g32 | (w_p32 & w_g10);
        assign w_blk_p[k] = w_p32 & w_p10;
    end

    // Remaining levels: prefix over block (G,P) pairs at distance 1,2,4,...
    // Indices are walked downward so each level reads only values that
    // still belong to the previous level.
    always_comb begin
        w_tree_g = w_blk_g;
        w_tree_p = w_blk_p;
        for (int l = 0; l < c_LOG_NBLK; l++) begin
            for (int k = c_NBLK - 1; k >= 0; k--) begin
                if (k >= (1 << l)) begin
                    w_tree_g[k] = w_tree_g[k] | (w_tree_p[k] & w_tree_g[k - (1 << l)]);
                    w_tree_p[k] = w_tree_p[k] & w_tree_p[k - (1 << l)];
                end
            end
        end
    end

    // w_c[k] is the carry into bit 4k.
    assign w_c = {w_tree_g, CIN};

    // Carry-select sum blocks.
    for (genvar k = 0; k < c_NBLK; k++) begin : g_sum
        logic [3:0] w_s0;
        logic [3:0] w_s1;
        logic       w_rc0;
        logic       w_rc1;

        always_comb begin
            w_rc0 = 1'b0;
            w_rc1 = 1'b1;
            w_s0  = '0;
            w_s1  = '0;
            for (int i = 0; i < 4; i++) begin
                w_s0[i] = w_p[4*k+i] ^ w_rc0;
                w_s1[i] = w_p[4*k+i] ^ w_rc1;
                w_rc0   = w_g[4*k+i] | (w_p[4*k+i] & w_rc0);
                w_rc1   = w_g[4*k+i] | (w_p[4*k+i] & w_rc1);
            end
        end

        assign w_sum[4*k +: 4] = w_c[k] ? w_s1 : w_s0;
    end

    assign Scomb = w_sum;
    assign COUT  = w_c[c_NBLK];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_c[c_NBLK];
        end
    end

    assign Ssync    = r_sum;
    assign COUTsync = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_p4_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_p4_adder
// Description : Self-checking bench for p4_adder.  Directed vectors and a
//               random run drive one operand pair per cycle; combinational
//               results are checked right after driving, and the expected
//               registered result is queued and checked after the next clk.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_p4_adder;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          cin;
    wire  [DW-1:0] scomb;
    wire           cout;
    wire  [DW-1:0] ssync;
    wire           coutsync;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          cin;
        logic [DW-1:0] s;
        logic          c;
    } vec_t;

    typedef struct {
        logic [DW-1:0] s;
        logic          c;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_vec = 0;
    int   n_err = 0;

    p4_adder #(.DWIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .Aif      (a),
        .Bif      (b),
        .CIN      (cin),
        .Scomb    (scomb),
        .COUT     (cout),
        .Ssync    (ssync),
        .COUTsync (coutsync)
    );

    always #5 clk = ~clk;

    task automatic check_v(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one operand pair at the falling edge, check the combinational
    // result, and queue the value the registers must hold after the next clk.
    task automatic apply(input logic [DW-1:0] ia, input logic [DW-1:0] ib, input logic ic,
                         input logic [DW-1:0] es, input logic ec);
        exp_t e;
        @(negedge clk);
        a   = ia;
        b   = ib;
        cin = ic;
        #1;
        check_v("Scomb", scomb, es);
        check_b("COUT", cout, ec);
        e.s = es;
        e.c = ec;
        sb.push_back(e);
    endtask

    // Registered-output scoreboard.
    always @(posedge clk) begin
        #1;
        if (!rst && sb.size() > 0) begin
            m_e = sb.pop_front();
            check_v("Ssync", ssync, m_e.s);
            check_b("COUTsync", coutsync, m_e.c);
        end
    end

    initial begin
        vec_t          vecs[$];
        vec_t          v;
        logic [DW:0]   ref_sum;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        logic          rc;

        // Directed table.
        vecs.push_back('{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0});
        vecs.push_back('{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0});
        // Carry crossing every 4-bit block boundary.
        for (int j = 1; j < DW / 4; j++) begin
            v.a   = (32'h1 << (4 * j)) - 32'h1;
            v.b   = 32'h1;
            v.cin = 1'b0;
            v.s   = 32'h1 << (4 * j);
            v.c   = 1'b0;
            vecs.push_back(v);
            // Same crossing driven by the carry-in instead of B.
            v.b   = 32'h0;
            v.cin = 1'b1;
            vecs.push_back(v);
        end

        // Reset state.
        rst = 1'b1;
        a   = '0;
        b   = '0;
        cin = 1'b0;
        #2;
        check_v("reset_Ssync", ssync, 32'h0);
        check_b("reset_COUTsync", coutsync, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c);

        // Asynchronous reset in the middle of a cycle with a value pending.
        apply(32'h1234_5670, 32'h0000_0008, 1'b0, 32'h1234_5678, 1'b0);
        apply(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0);
        @(posedge clk);
        #1;
        apply(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
        #1;
        check_v("pre_rst_Ssync", ssync, 32'h0000_0008);
        rst = 1'b1;
        sb.delete();
        #1;
        check_v("async_rst_Ssync", ssync, 32'h0);
        check_b("async_rst_COUTsync", coutsync, 1'b0);
        check_v("rst_Scomb", scomb, 32'h0);
        check_b("rst_COUT", cout, 1'b1);
        @(posedge clk);
        #2;
        check_v("held_rst_Ssync", ssync, 32'h0);
        check_b("held_rst_COUTsync", coutsync, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        // First clk after release loads the current sum.
        apply(32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0);

        // Random back-to-back regression.
        for (int i = 0; i < 10000; i++) begin
            ra      = $urandom;
            rb      = $urandom;
            rc      = 1'($urandom_range(0, 1));
            ref_sum = {1'b0, ra} + {1'b0, rb} + {{DW{1'b0}}, rc};
            apply(ra, rb, rc, ref_sum[DW-1:0], ref_sum[DW]);
        end

        @(posedge clk);
        #3;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d registered results not observed, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
